pipeline_debug_unit: RTL and testbench
======================================

Name: pipeline_debug_unit

Overview:
- Host-side controller for the 5-stage MIPS pipeline; the other end of the pipeline's debug interface.
- Takes command bytes from a UART receiver and gates the pipeline via clkEnable: run, single-step, pipeline reset.
- After a run or step it serializes the pipeline's exposed state (PC, cycle count, register file, data memory) into a byte stream for a UART transmitter.
- Sits between the UART rx/tx and the pipeline top.

Parameters:
- PC_BITS, 10, width of PC_IFID.
- REG_BITS, 1024, flattened register file (32 x 32-bit; word i at [32i+31:32i]).
- MEM_BITS, 320, flattened data memory (10 x 32-bit; word i at [32i+31:32i]).
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops continuous run.
- DRAIN_CYCLES, 4, extra enabled cycles after HALT_WORD is fetched, so older instructions retire.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received command byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle request to send tx_data.
- clkEnable  out  1  pipeline clock enable.
- pipe_reset  out  1  pipeline reset request.
- instruction  in  32  instruction currently in IF/ID.
- PC_IFID  in  PC_BITS  PC in IF/ID.
- Registers  in  REG_BITS  register file contents.
- Memorias  in  MEM_BITS  data memory contents.
- busy  out  1  high whenever not in IDLE.

Behaviour:
- Reset: all outputs 0, cycle counter 0, drain counter 0, state IDLE.
- All outputs are registered.

States:
- IDLE, RUN, DRAIN, STEP, RST, DUMP_SEND, DUMP_WAIT_HI, DUMP_WAIT_LO.

IDLE:
- Acts only on rx_valid; any other byte is ignored.
- 0x63 'c' -> RUN.
- 0x73 's' -> STEP.
- 0x64 'd' -> DUMP_SEND.
- 0x72 'r' -> RST.

RUN:
- clkEnable=1.
- When the sampled instruction equals HALT_WORD -> DRAIN, drain counter loaded with DRAIN_CYCLES.

DRAIN:
- clkEnable=1; counter decrements each cycle.
- At 0: clkEnable=0 -> DUMP_SEND.
- DRAIN_CYCLES=0 skips directly to DUMP_SEND.

STEP:
- clkEnable=1 for exactly one cycle, then 0 -> DUMP_SEND.

RST:
- pipe_reset=1 and clkEnable=0 for 2 cycles.
- Cycle counter cleared; no dump -> IDLE.

Cycle counter:
- 32-bit, increments on every cycle clkEnable=1.
- Saturates at 32'hFFFFFFFF.

Dump:
- clkEnable is held 0 for the whole dump, so the inputs are stable and are indexed live; no snapshot is taken.
- Byte index 0..173. PC and counter bytes are sent MSB first:
  - 0-1: PC zero-extended to 16 bits.
  - 2-5: cycle counter.
  - 6-133: registers, word 0 first, each word MSB byte first.
  - 134-173: memory, word 0 first, each word MSB byte first.

Tx handshake:
- DUMP_SEND: waits for tx_busy=0, then drives tx_data and a 1-cycle tx_start -> DUMP_WAIT_HI.
- DUMP_WAIT_HI: waits for tx_busy=1 -> DUMP_WAIT_LO.
- DUMP_WAIT_LO: waits for tx_busy=0; if last byte -> IDLE, else index+1 -> DUMP_SEND.
- tx_data holds its value until the next tx_start.

Boundary cases:
- rx_valid outside IDLE: dropped, not queued.
- HALT_WORD present when 'c' is accepted: still enters RUN; the halt is detected in the first RUN cycle, and RUN contributes 1 enabled cycle before DRAIN.
- reset during any state: immediate return to reset values; a partial frame is abandoned.
- busy=0 only in IDLE.

Optional Feature:
- Macro: DEBUG_CHECKSUM_EN.
- Defined: one extra byte (index 174) is appended; it is the XOR of bytes 0-173. Frame length 175.
- Undefined: frame length 174, no checksum logic.

Test Plan:
- Reset, then 's'; PC_IFID=10'h004, Registers word1=32'h12345678 -> clkEnable high exactly 1 cycle; frame starts 00 04 00 00 00 01; bytes 10-13 = 12 34 56 78.
- 'c', instruction becomes HALT_WORD after 7 enabled cycles (fetched on the 8th), DRAIN_CYCLES=4 -> clkEnable high 12 cycles total, then low; frame bytes 2-5 = 00 00 00 0C; busy falls after 174 tx_start pulses.
- Memorias word9=32'hDEADBEEF, 'd' -> bytes 170-173 = DE AD BE EF; clkEnable never asserted; counter unchanged.
- tx_busy held high 50 cycles after each tx_start -> exactly one tx_start per byte, never while tx_busy=1; rx_valid 's' mid-dump ignored.
- After steps, 'r' -> pipe_reset high exactly 2 cycles, no tx_start; next 's' frame shows counter 00 00 00 01.
- reset asserted at dump byte 50 -> outputs 0 asynchronously; next 'd' restarts at byte 0. With DEBUG_CHECKSUM_EN: all-zero state, 'd' -> byte 174 = 00.

Source files
------------

// File: rtl/pipeline_debug_unit.sv
// pipeline_debug_unit: host-side debug controller that gates a MIPS pipeline from UART commands and dumps its state
// Ports: clk, reset (async, active-high); rx_data/rx_valid command bytes in; tx_busy/tx_data/tx_start byte stream out;
//   clkEnable, pipe_reset to the pipeline; instruction, PC_IFID, Registers, Memorias pipeline state in; busy when not idle.
// Optional: define DEBUG_CHECKSUM_EN to append an XOR checksum byte to every dump frame.
module pipeline_debug_unit #(
  parameter int          PC_BITS      = 10,
  parameter int          REG_BITS     = 1024,
  parameter int          MEM_BITS     = 320,
  parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                tx_busy,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  output logic                clkEnable,
  output logic                pipe_reset,
  input  logic [31:0]         instruction,
  input  logic [PC_BITS-1:0]  PC_IFID,
  input  logic [REG_BITS-1:0] Registers,
  input  logic [MEM_BITS-1:0] Memorias,
  output logic                busy
);
  localparam int          RW        = $clog2(REG_BITS);
  localparam int          MW        = $clog2(MEM_BITS);
  localparam logic [15:0] REG_START = 16'd6;
  localparam logic [15:0] MEM_START = 16'(6 + REG_BITS / 8);
  localparam logic [15:0] DATA_END  = 16'(6 + REG_BITS / 8 + MEM_BITS / 8);
`ifdef DEBUG_CHECKSUM_EN
  localparam logic [15:0] LAST = DATA_END;
`else
  localparam logic [15:0] LAST = DATA_END - 16'd1;
`endif

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, STEP, RST, DUMP_SEND, DUMP_WAIT_HI, DUMP_WAIT_LO} state_t;

  state_t         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d, drain_q, drain_d;
  logic [15:0]    idx_q, idx_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_start_q, tx_start_d, clk_enable_q, clk_enable_d;
  logic           pipe_reset_q, pipe_reset_d, busy_q, busy_d;
  logic           send;
  logic [7:0]     byte_sel, tail;
  logic [15:0]    pc16, r_rel, m_rel;
  logic [4:0]     c_off;
  logic [RW-1:0]  r_off;
  logic [MW-1:0]  m_off;
`ifdef DEBUG_CHECKSUM_EN
  logic [7:0]     chk_q, chk_d;
`endif

  // Inputs are frozen during a dump (clkEnable low), so bytes are picked live by index.
  // Byte b of a word goes out MSB first, hence the inverted low index bits.
  always_comb begin
    pc16  = 16'(PC_IFID);
    c_off = {2'd1 - idx_q[1:0], 3'b000};
    r_rel = idx_q - REG_START;
    m_rel = idx_q - MEM_START;
    r_off = RW'({r_rel[15:2], ~r_rel[1:0], 3'b000});
    m_off = MW'({m_rel[15:2], ~m_rel[1:0], 3'b000});
`ifdef DEBUG_CHECKSUM_EN
    tail  = chk_q;
`else
    tail  = 8'h00;
`endif
    byte_sel = idx_q < 16'd2   ? (idx_q[0] ? pc16[7:0] : pc16[15:8]) :
               idx_q < REG_START ? cnt_q[c_off +: 8] :
               idx_q < MEM_START ? Registers[r_off +: 8] :
               idx_q < DATA_END  ? Memorias[m_off +: 8] : tail;
  end

  always_comb begin
    send      = state_q == DUMP_SEND && !tx_busy;
    state_d   = state_q;
    drain_d   = drain_q;
    idx_d     = idx_q;
    cnt_d     = state_q == RST ? 32'd0 : (clk_enable_q && cnt_q != 32'hFFFFFFFF) ? cnt_q + 32'd1 : cnt_q;
    tx_data_d = send ? byte_sel : tx_data_q;
    case (state_q)
      IDLE: if (rx_valid) begin
        state_d = rx_data == 8'h63 ? RUN : rx_data == 8'h73 ? STEP :
                  rx_data == 8'h64 ? DUMP_SEND : rx_data == 8'h72 ? RST : IDLE;
        drain_d = rx_data == 8'h72 ? 32'd1 : drain_q;
      end
      RUN: if (instruction == HALT_WORD) begin
        state_d = DRAIN_CYCLES == 0 ? DUMP_SEND : DRAIN;
        drain_d = 32'(DRAIN_CYCLES);
      end
      DRAIN: begin
        drain_d = drain_q - 32'd1;
        state_d = drain_q == 32'd1 ? DUMP_SEND : DRAIN;
      end
      STEP: state_d = DUMP_SEND;
      RST: begin
        state_d = drain_q == 32'd0 ? IDLE : RST;
        drain_d = drain_q == 32'd0 ? 32'd0 : drain_q - 32'd1;
      end
      DUMP_SEND: state_d = send ? DUMP_WAIT_HI : DUMP_SEND;
      DUMP_WAIT_HI: state_d = tx_busy ? DUMP_WAIT_LO : DUMP_WAIT_HI;
      DUMP_WAIT_LO: if (!tx_busy) begin
        state_d = idx_q == LAST ? IDLE : DUMP_SEND;
        idx_d   = idx_q == LAST ? 16'd0 : idx_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs follow the next state so they are registered yet aligned with the state they belong to.
    clk_enable_d = state_d inside {RUN, DRAIN, STEP};
    pipe_reset_d = state_d == RST;
    busy_d       = state_d != IDLE;
    tx_start_d   = send;
  end

`ifdef DEBUG_CHECKSUM_EN
  assign chk_d = send ? chk_q ^ byte_sel : state_q == IDLE ? 8'h00 : chk_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      clk_enable_q <= 1'b0;
      pipe_reset_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DEBUG_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      clk_enable_q <= clk_enable_d;
      pipe_reset_q <= pipe_reset_d;
      busy_q       <= busy_d;
`ifdef DEBUG_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign clkEnable  = clk_enable_q;
  assign pipe_reset = pipe_reset_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_pipeline_debug_unit.sv
// tb_pipeline_debug_unit: scoreboard bench for pipeline_debug_unit with a UART tx model and a pipeline stand-in
module tb_pipeline_debug_unit;
`ifdef DEBUG_CHECKSUM_EN
  localparam int FRAME = 175;
`else
  localparam int FRAME = 174;
`endif
  logic          clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, tx_busy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [31:0]   instruction = 32'h0;
  logic [9:0]    pc = 10'h0;
  logic [1023:0] regs = '0;
  logic [319:0]  mem = '0;
  logic [7:0]    tx_data;
  logic          tx_start, clk_en, pipe_reset, busy;
  int            n_err = 0, n_chk = 0, ntx = 0, en_cnt = 0, pr_cnt = 0;
  int            halt_after = 1000, busy_len = 3, busy_left = 0;
  logic [31:0]   cnt_model = 0;
  logic [7:0]    sb[$];

  pipeline_debug_unit dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .clkEnable(clk_en), .pipe_reset(pipe_reset),
    .instruction(instruction), .PC_IFID(pc), .Registers(regs), .Memorias(mem), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void push_frame();
    logic [15:0] p = 16'(pc);
    logic [7:0]  x = 8'h00;
    logic [7:0]  f[$];
    f.push_back(p[15:8]);
    f.push_back(p[7:0]);
    for (int i = 3; i >= 0; i--) f.push_back(cnt_model[8*i +: 8]);
    for (int w = 0; w < 32; w++) for (int i = 3; i >= 0; i--) f.push_back(regs[32*w + 8*i +: 8]);
    for (int w = 0; w < 10; w++) for (int i = 3; i >= 0; i--) f.push_back(mem[32*w + 8*i +: 8]);
    foreach (f[i]) x ^= f[i];
`ifdef DEBUG_CHECKSUM_EN
    f.push_back(x);
`endif
    foreach (f[i]) sb.push_back(f[i]);
  endfunction

  // Pipeline stand-in, UART transmitter model and scoreboard consumer, all on the falling edge.
  initial forever begin
    @(negedge clk);
    instruction = en_cnt >= halt_after ? 32'hFFFFFFFF : 32'h00000013;
    if (clk_en) en_cnt++;
    if (pipe_reset) pr_cnt++;
    if (tx_start) begin
      check("tx_while_busy", 32'(tx_busy), 0);
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) check($sformatf("byte%0d", ntx), 32'(tx_data), 32'(sb.pop_front()));
      ntx++;
      tx_busy = 1'b1;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  end

  task automatic check_quiet(string tag);
    check({tag, "_txd"}, 32'(tx_data), 0);
    check({tag, "_txs"}, 32'(tx_start), 0);
    check({tag, "_en"}, 32'(clk_en), 0);
    check({tag, "_prst"}, 32'(pipe_reset), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic send(logic [7:0] c);
    @(negedge clk);
    rx_data = c;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt_model = 0;
  endtask

  task automatic run_cmd(string tag, logic [7:0] c, int en_exp, bit dump, int poke = 0);
    int n = 0;
    en_cnt = 0;
    ntx = 0;
    pr_cnt = 0;
    cnt_model = c == 8'h72 ? 32'd0 : cnt_model + 32'(en_exp);
    if (dump) push_frame();
    send(c);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      send(8'h73);
    end
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_en"}, en_cnt, en_exp);
    check({tag, "_ntx"}, ntx, dump ? FRAME : 0);
    check({tag, "_sb"}, sb.size(), 0);
  endtask

  initial begin
    int n = 0;
    repeat (2) @(negedge clk);
    check_quiet("rst");
    reset = 1'b0;
    for (int w = 0; w < 32; w++) regs[32*w +: 32] = $urandom;
    for (int w = 0; w < 10; w++) mem[32*w +: 32] = $urandom;
    regs[63:32] = 32'h12345678;
    pc = 10'h004;
    run_cmd("step", 8'h73, 1, 1);
    do_reset();
    halt_after = 7;
    run_cmd("run", 8'h63, 12, 1);
    halt_after = 0;
    run_cmd("run_h0", 8'h63, 5, 1);
    halt_after = 1000;
    mem[319:288] = 32'hDEADBEEF;
    busy_len = 50;
    run_cmd("dump", 8'h64, 0, 1, 300);
    busy_len = 3;
    run_cmd("step2", 8'h73, 1, 1);
    run_cmd("rcmd", 8'h72, 0, 0);
    check("rcmd_pulse", pr_cnt, 2);
    run_cmd("step3", 8'h73, 1, 1);
    ntx = 0;
    push_frame();
    send(8'h64);
    while (ntx < 51 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_b50", 32'(ntx >= 51), 1);
    #2 reset = 1'b1;
    #1 check_quiet("arst");
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt_model = 0;
    repeat (5) @(negedge clk);
    run_cmd("redump", 8'h64, 0, 1);
    regs = '0;
    mem = '0;
    pc = 10'h0;
    do_reset();
    run_cmd("zero", 8'h64, 0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
